// File: rtl/ShellTypes.sv
// ShellTypes: shared UMI transport types and line-size constants used by the
// shell-side initiators and responders.
package ShellTypes;

    localparam int UMI_LINE_BYTES = 64;
    localparam int UMI_LINE_LOG   = 6;
    localparam int UMI_DATA_BITS  = UMI_LINE_BYTES * 8;

    typedef struct packed {
        logic        valid;
        logic        isWrite;
        logic [63:0] addr;
        logic [63:0] size;
    } UMIReq;

    typedef struct packed {
        logic                     valid;
        logic [UMI_DATA_BITS-1:0] data;
    } UMIWriteData;

    typedef struct packed {
        logic                     valid;
        logic [UMI_DATA_BITS-1:0] data;
    } UMIReadData;

    // A request is well formed only when it covers exactly one aligned line.
    function automatic logic umi_is_malformed(input logic [UMI_LINE_LOG-1:0] addr_low,
                                              input logic [63:0]             size);
        return (size != 64'(UMI_LINE_BYTES)) || (addr_low != '0);
    endfunction

endpackage

// File: rtl/FIFO.sv
// FIFO: generic synchronous FIFO with occupancy count. Pops while empty are
// ignored; pushing into a full FIFO without a simultaneous pop is illegal.
module FIFO #(
    parameter int WIDTH     = 8,
    parameter int LOG_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 push,
    input  logic [WIDTH-1:0]     din,
    input  logic                 pop,
    output logic [WIDTH-1:0]     dout,
    output logic                 empty,
    output logic [LOG_DEPTH:0]   count
);

    localparam int DEPTH = 2 ** LOG_DEPTH;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr;
    logic [LOG_DEPTH-1:0] rd_ptr;
    logic                 do_pop;

    assign empty  = (count == '0);
    assign do_pop = pop && !empty;
    assign dout   = mem[rd_ptr];

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + LOG_DEPTH'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + LOG_DEPTH'(1);
            end
            count <= count + (LOG_DEPTH+1)'(push) - (LOG_DEPTH+1)'(do_pop);
        end
    end

    // Storage array is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    overflow_check: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !do_pop && (count == (LOG_DEPTH+1)'(DEPTH))));

endmodule

// File: rtl/umi_line_ram.sv
// umi_line_ram: single-port synchronous RAM of whole 64-byte lines. On a write
// the output register takes the new data (write-first behaviour).
module umi_line_ram #(
    parameter int LOG_WORDS = 10,
    parameter int WIDTH     = 512
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [LOG_WORDS-1:0] addr,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [2 ** LOG_WORDS];

    // One access per enabled cycle; writes forward their data to the read port.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata     <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/umi_mem_responder.sv
// umi_mem_responder: UMI target backed by on-chip line RAM, returning in-order
// read data through a credit-protected response FIFO.
// Optional feature macro: UMI_RESP_RANDOM_STALL_EN adds LFSR-driven backpressure.
module umi_mem_responder
    import ShellTypes::*;
#(
    parameter int          LOG_WORDS      = 10,
    parameter int          LOG_RESP_DEPTH = 4,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  UMIReq       umi_req_in,
    output logic        umi_req_grant_out,
    input  UMIWriteData umi_write_in,
    output logic        umi_write_ready_out,
    output UMIReadData  umi_read_out,
    input  logic        umi_read_grant_in,
    output logic [31:0] err_count_out
);

    localparam int RESP_DEPTH = 2 ** LOG_RESP_DEPTH;
    localparam int CREDIT_W   = LOG_RESP_DEPTH + 2;

    logic                     active;
    logic                     stall;
    logic                     malformed;
    logic [LOG_WORDS-1:0]     word_idx;
    logic                     credit_ok;
    logic                     write_grant;
    logic                     read_grant;
    logic                     ram_en;
    logic                     ram_we;
    logic [UMI_DATA_BITS-1:0] ram_rdata;
    logic                     inflight;
    logic                     inflight_zero;
    logic [LOG_RESP_DEPTH:0]  fifo_count;
    logic                     fifo_empty;
    UMIReadData               push_entry;
    UMIReadData               fifo_head;
    logic                     unused_bits;

`ifdef UMI_RESP_RANDOM_STALL_EN
    logic [15:0] lfsr;
    logic        feedback;

    assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign stall    = (lfsr[1:0] == 2'b00);

    // Fibonacci LFSR (taps 16,14,13,11) stepping every cycle to inject stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], feedback};
        end
    end
`else
    logic [15:0] unused_seed;

    assign stall       = 1'b0;
    assign unused_seed = LFSR_SEED;
`endif

    assign word_idx  = umi_req_in.addr[LOG_WORDS+UMI_LINE_LOG-1:UMI_LINE_LOG];
    assign malformed = umi_is_malformed(umi_req_in.addr[UMI_LINE_LOG-1:0], umi_req_in.size);
    assign credit_ok = (CREDIT_W'(fifo_count) + CREDIT_W'(inflight)) < CREDIT_W'(RESP_DEPTH);

    // Grants are suppressed until the first clock after reset release so
    // deassertion behaves synchronously; only one request can win per cycle.
    always_comb begin
        write_grant = 1'b0;
        read_grant  = 1'b0;
        if (active && !stall && umi_req_in.valid) begin
            if (umi_req_in.isWrite) begin
                write_grant = umi_write_in.valid;
            end else begin
                read_grant = credit_ok;
            end
        end
    end

    assign umi_req_grant_out   = write_grant || read_grant;
    assign umi_write_ready_out = active && !stall;
    assign ram_we              = write_grant && !malformed;
    assign ram_en              = read_grant || ram_we;

    umi_line_ram #(
        .LOG_WORDS (LOG_WORDS),
        .WIDTH     (UMI_DATA_BITS)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (word_idx),
        .wdata (umi_write_in.data),
        .rdata (ram_rdata)
    );

    // Track the one-cycle RAM read in flight and the malformed-request counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active        <= 1'b0;
            inflight      <= 1'b0;
            inflight_zero <= 1'b0;
            err_count_out <= '0;
        end else begin
            active        <= 1'b1;
            inflight      <= read_grant;
            inflight_zero <= read_grant && malformed;
            if (umi_req_grant_out && malformed && (err_count_out != 32'hFFFF_FFFF)) begin
                err_count_out <= err_count_out + 32'd1;
            end
        end
    end

    assign push_entry.valid = 1'b1;
    assign push_entry.data  = inflight_zero ? '0 : ram_rdata;

    FIFO #(
        .WIDTH     ($bits(UMIReadData)),
        .LOG_DEPTH (LOG_RESP_DEPTH)
    ) u_resp_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (inflight),
        .din     (push_entry),
        .pop     (umi_read_grant_in),
        .dout    (fifo_head),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign umi_read_out.valid = !fifo_empty;
    assign umi_read_out.data  = fifo_head.data;

    assign unused_bits = ^{umi_req_in.addr[63:LOG_WORDS+UMI_LINE_LOG], fifo_head.valid};

endmodule

// File: tb/tb_umi_mem_responder.sv
// tb_umi_mem_responder: directed scoreboard bench for umi_mem_responder; with
// UMI_RESP_RANDOM_STALL_EN defined it runs randomized traffic instead.
module tb_umi_mem_responder;
    import ShellTypes::*;

    localparam int LOG_WORDS = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    UMIReq       umi_req_in;
    logic        umi_req_grant_out;
    UMIWriteData umi_write_in;
    logic        umi_write_ready_out;
    UMIReadData  umi_read_out;
    logic        umi_read_grant_in;
    logic [31:0] err_count_out;

    int vectors     = 0;
    int miscompares = 0;
    int resp_count  = 0;
    int err_exp     = 0;

    logic [511:0] exp_q [$];
    logic [511:0] model_mem [1 << LOG_WORDS];

    always #5 clk = ~clk;

    umi_mem_responder #(
        .LOG_WORDS      (LOG_WORDS),
        .LOG_RESP_DEPTH (4),
        .LFSR_SEED      (16'hACE1)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .umi_req_in          (umi_req_in),
        .umi_req_grant_out   (umi_req_grant_out),
        .umi_write_in        (umi_write_in),
        .umi_write_ready_out (umi_write_ready_out),
        .umi_read_out        (umi_read_out),
        .umi_read_grant_in   (umi_read_grant_in),
        .err_count_out       (err_count_out)
    );

    task automatic check_output(input string tag, input logic [511:0] observed,
                                input logic [511:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic UMIReq mk_req(input logic is_write, input logic [63:0] addr,
                                     input logic [63:0] size);
        UMIReq r;
        r.valid   = 1'b1;
        r.isWrite = is_write;
        r.addr    = addr;
        r.size    = size;
        return r;
    endfunction

    function automatic logic bad_req(input logic [63:0] addr, input logic [63:0] size);
        return (size != 64'd64) || (addr[5:0] != 6'd0);
    endfunction

    function automatic logic [511:0] pattern(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(i);
        return {16{w}};
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] d;
        for (int k = 0; k < 16; k++) begin
            d[k*32 +: 32] = $urandom;
        end
        return d;
    endfunction

    // Wait (bounded) for the current request to be granted; returns just after the grant edge.
    task automatic wait_grant(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (umi_req_grant_out === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            if (i >= 4) umi_read_grant_in = 1'b1;
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [511:0] data,
                            input logic [63:0] size);
        logic ok;
        umi_req_in   = mk_req(1'b1, addr, size);
        umi_write_in = '{valid: 1'b1, data: data};
        wait_grant(ok);
        umi_req_in   = '0;
        umi_write_in = '0;
        check_output("write_granted", 512'(ok), 512'd1);
        if (ok) begin
            if (bad_req(addr, size)) err_exp++;
            else model_mem[addr[LOG_WORDS+5:6]] = data;
        end
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [63:0] size);
        logic ok;
        umi_req_in = mk_req(1'b0, addr, size);
        wait_grant(ok);
        umi_req_in = '0;
        check_output("read_granted", 512'(ok), 512'd1);
        if (ok) begin
            if (bad_req(addr, size)) begin
                err_exp++;
                exp_q.push_back('0);
            end else begin
                exp_q.push_back(model_mem[addr[LOG_WORDS+5:6]]);
            end
        end
    endtask

    // Present back-to-back line reads until target grants or the cycle budget runs out.
    task automatic stream_reads(input int target, input int budget, inout int issued);
        for (int c = 0; c < budget && issued < target; c++) begin
            umi_req_in = mk_req(1'b0, 64'(issued) * 64, 64'd64);
            @(negedge clk);
            if (umi_req_grant_out === 1'b1) begin
                exp_q.push_back(model_mem[issued]);
                issued++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && umi_read_out.valid !== 1'b1) break;
        end
        check_output("drain_empty", 512'(exp_q.size()), 512'd0);
        @(posedge clk);
        #1;
    endtask

    // Response monitor: every accepted read beat must match the scoreboard head.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && umi_read_out.valid === 1'b1 && umi_read_grant_in === 1'b1) begin
            resp_count++;
            check_output("read_expected", 512'(exp_q.size() != 0), 512'd1);
            if (exp_q.size() != 0) begin
                check_output("read_data", umi_read_out.data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        int issued;
        int base;

        reset_n           = 1'b0;
        umi_req_in        = mk_req(1'b1, 64'h40, 64'd64);
        umi_write_in      = '{valid: 1'b1, data: '1};
        umi_read_grant_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_grant", 512'(umi_req_grant_out), 512'd0);
        check_output("reset_write_ready", 512'(umi_write_ready_out), 512'd0);
        check_output("reset_read_valid", 512'(umi_read_out.valid), 512'd0);
        check_output("reset_err_count", 512'(err_count_out), 512'd0);
        @(posedge clk);
        #1;
        umi_req_in   = '0;
        umi_write_in = '0;
        reset_n      = 1'b1;
        @(posedge clk);
        #1;
        umi_read_grant_in = 1'b1;

`ifndef UMI_RESP_RANDOM_STALL_EN
        @(negedge clk);
        check_output("write_ready_idle", 512'(umi_write_ready_out), 512'd1);
        @(posedge clk);
        #1;

        $display("[TB] write/read line 0x40 with latency check");
        do_write(64'h40, {64{8'hA5}}, 64'd64);
        do_read(64'h40, 64'd64);
        @(negedge clk);
        check_output("latency_cycle1_valid", 512'(umi_read_out.valid), 512'd0);
        @(negedge clk);
        check_output("latency_cycle2_valid", 512'(umi_read_out.valid), 512'd1);
        check_output("err_count_clean", 512'(err_count_out), 512'(err_exp));
        wait_drain(50);

        $display("[TB] credit limit with 20 outstanding reads");
        for (int i = 0; i < 20; i++) do_write(64'(i) * 64, pattern(i), 64'd64);
        umi_read_grant_in = 1'b0;
        issued = 0;
        stream_reads(20, 40, issued);
        check_output("credit_grants", 512'(issued), 512'd16);
        @(negedge clk);
        check_output("grant_held_low", 512'(umi_req_grant_out), 512'd0);
        check_output("full_read_valid", 512'(umi_read_out.valid), 512'd1);
        @(posedge clk);
        #1;
        base = resp_count;
        umi_read_grant_in = 1'b1;
        stream_reads(20, 100, issued);
        umi_req_in = '0;
        check_output("all_reads_granted", 512'(issued), 512'd20);
        wait_drain(100);
        check_output("response_count", 512'(resp_count - base), 512'd20);

        $display("[TB] read-after-write in consecutive cycles");
        do_write(64'h80, {16{32'h1234_5678}}, 64'd64);
        do_read(64'h80, 64'd64);
        wait_drain(50);

        $display("[TB] malformed requests");
        do_read(64'h41, 64'd32);
        wait_drain(50);
        check_output("err_count_bad_read", 512'(err_count_out), 512'(err_exp));
        do_write(64'h48, {16{32'hDEAD_BEEF}}, 64'd64);
        @(negedge clk);
        check_output("err_count_bad_write", 512'(err_count_out), 512'(err_exp));
        @(posedge clk);
        #1;
        do_read(64'h40, 64'd64);
        wait_drain(50);

        $display("[TB] upper address bits alias");
        do_write(64'h10000, {8{64'hFEED_FACE_0BAD_F00D}}, 64'd64);
        do_read(64'h0, 64'd64);
        wait_drain(50);

        $display("[TB] reset with queued reads");
        umi_read_grant_in = 1'b0;
        for (int i = 0; i < 5; i++) do_read(64'(i) * 64, 64'd64);
        @(negedge clk);
        @(negedge clk);
        check_output("queued_valid", 512'(umi_read_out.valid), 512'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("reset_drops_valid", 512'(umi_read_out.valid), 512'd0);
        exp_q.delete();
        err_exp = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_output("post_reset_empty", 512'(umi_read_out.valid), 512'd0);
        check_output("post_reset_err", 512'(err_count_out), 512'(err_exp));
        @(posedge clk);
        #1;
        umi_read_grant_in = 1'b1;
        do_read(64'h40, 64'd64);
        wait_drain(50);
`else
        $display("[TB] randomized traffic under stall");
        for (int i = 0; i < 16; i++) do_write(64'(i) * 64, rand_line(), 64'd64);
        for (int n = 0; n < 1000; n++) begin
            int op;
            int line;
            umi_read_grant_in = ($urandom_range(0, 3) != 0);
            op   = $urandom_range(0, 9);
            line = $urandom_range(0, 15);
            if (op < 4) do_write(64'(line) * 64, rand_line(), 64'd64);
            else if (op == 4) do_write(64'(line) * 64 + 64'd8, rand_line(), 64'd64);
            else if (op == 9) do_read(64'(line) * 64 + 64'd4, 64'd64);
            else do_read(64'(line) * 64, 64'd64);
        end
        umi_read_grant_in = 1'b1;
        wait_drain(2000);
        check_output("random_err_count", 512'(err_count_out), 512'(err_exp));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/umi_mem_responder.md
Name: umi_mem_responder

Overview:
- UMI responder (target side) backed by on-chip synchronous RAM; the counterpart of the MemReq-to-UMI initiator.
- Accepts UMI read/write requests and 64-byte write data, and returns in-order read data with a credit-protected response buffer.
- Used as a DRAM stand-in for simulation and for FPGA builds without a DRAM controller.

Parameters:
- LOG_WORDS, 10, log2 of RAM depth in 64-byte lines; addressable span is 2^LOG_WORDS*64 bytes.
- LOG_RESP_DEPTH, 4, log2 of the read-response FIFO depth.
- LFSR_SEED, 16'hACE1, nonzero seed for the optional stall generator.

Ports:
- clk  in  1  user clock.
- reset_n  in  1  asynchronous active-low reset.
- umi_req_in  in  $bits(UMIReq)  request {valid, isWrite, addr[63:0], size[63:0]}.
- umi_req_grant_out  out  1  request consumed this cycle.
- umi_write_in  in  $bits(UMIWriteData)  write data {valid, data[511:0]}.
- umi_write_ready_out  out  1  responder can take a write this cycle.
- umi_read_out  out  $bits(UMIReadData)  read response {valid, data[511:0]}.
- umi_read_grant_in  in  1  initiator accepts the presented read data.
- err_count_out  out  32  saturating count of malformed requests.

Behaviour:
- Reset is async assert, sync deassert. During and after reset: grant=0, write_ready=0, read_out.valid=0, err_count=0, FIFO empty, in-flight=0. RAM contents are not reset.
- Word index is addr[LOG_WORDS+5:6]. Upper address bits wrap (are ignored).
- One request is granted per cycle, with no reordering.
- Malformed request: size != 64 or addr[5:0] != 0.
  - Still granted, so the initiator never deadlocks.
  - A write is dropped. A read returns data of all zeros.
  - err_count increments and saturates at 32'hFFFFFFFF.
- credit_ok = (fifo_count + inflight) < 2^LOG_RESP_DEPTH.
- write_ready = !stall (stall is 0 unless the optional feature is compiled in).
- Write grant = req.valid && req.isWrite && write.valid && !stall.
  - The RAM write occurs on that clock edge.
  - A write request without write.valid in the same cycle is held, not granted.
- Read grant = req.valid && !req.isWrite && credit_ok && !stall.
  - The RAM is read on the grant edge; data is pushed into the FIFO on the next edge (inflight 1 -> 0).
  - Request-to-read-valid latency is 2 cycles when the FIFO is empty.
- Read-after-write to the same word in consecutive cycles returns the new data (write-first RAM).
- read_out.valid = !fifo_empty, and read_out.data = FIFO head.
- Pop = read_grant_in && !fifo_empty. A grant while empty is ignored.
- Push and pop in the same cycle keep the count unchanged. The FIFO can never overflow because of the credit check; overflow is an assertion failure.
- Reset mid-operation discards queued and in-flight reads.

Optional Feature:
- Macro: UMI_RESP_RANDOM_STALL_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded with LFSR_SEED on reset and steps every cycle.
  - stall = (lfsr[1:0] == 2'b00), giving roughly 25% backpressure on both grants and write_ready.
- When undefined: stall is tied to 0 and no LFSR logic exists.

Decomposition:
- UMIReq, UMIWriteData and UMIReadData stay in ShellTypes.
- Add UMI_LINE_BYTES=64 and UMI_LINE_LOG=6 to ShellTypes.
- The response buffer is the existing FIFO module (WIDTH=$bits(UMIReadData), LOG_DEPTH=LOG_RESP_DEPTH).
- One natural sub-module: umi_line_ram, a single-port write-first synchronous RAM of 2^LOG_WORDS x 512 bits.

Test Plan:
- Write addr 0x40 data 512'hA5 (repeated pattern), then read 0x40 -> read valid exactly 2 cycles after the read grant, data matches, err_count=0.
- Issue 20 reads with read_grant_in=0 -> exactly 16 grants, then grant stays low. Release read_grant_in -> 20 responses in address order.
- Write 0x80 then read 0x80 on the next cycle -> the new data is returned.
- Read with size=32 at addr 0x41 -> request granted, zero data returned, err_count=1. A bad write leaves the RAM unchanged.
- Addr 0x10000 with LOG_WORDS=10 aliases to word 0 -> reading 0x0 returns that data.
- Assert reset_n=0 with 5 reads queued -> read valid drops immediately and the FIFO is empty after release. With UMI_RESP_RANDOM_STALL_EN, 1000 random ops match a scoreboard.
